// File: rtl/iob_reg_file_arb_pkg.sv
// Shared types and helpers for the register-file arbiter.
package iob_reg_file_arb_pkg;

  // Widest requester id (up to 16 requesters).
  localparam int unsigned ID_MAX_W = 4;

  // Per-port record of what was granted last cycle.
  typedef struct packed {
    logic                valid;
    logic                is_read;
    logic [ID_MAX_W-1:0] id;
  } port_rec_t;

  // Increment with wrap at n.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/iob_rr_sel.sv
// First-set-at-or-after-pointer selector: one-hot grant, its index and a found flag.
module iob_rr_sel #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt_c,
  output logic [ID_W-1:0]  idx_c,
  output logic             found_c
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] pos;

  // Scan from ptr upward, wrapping at N_REQ; first set bit wins.
  always_comb begin
    gnt_c   = '0;
    idx_c   = '0;
    found_c = 1'b0;
    sum     = '0;
    pos     = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
      pos = sum[ID_W-1:0];
      if (!found_c && req[pos]) begin
        found_c  = 1'b1;
        gnt_c[pos] = 1'b1;
        idx_c    = pos;
      end
    end
  end

endmodule

// File: rtl/iob_reg_file_arb.sv
// Dual-port register file arbiter: grants up to two requesters per cycle (A, B),
// returns read data one cycle after grant.
// Build option: IOB_REG_FILE_ARB_RR_EN selects a round-robin pointer; otherwise
// fixed priority with requester 0 highest.
module iob_reg_file_arb
  import iob_reg_file_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned NUM_COL    = 2,
  parameter int unsigned COL_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [N_REQ*NUM_COL-1:0]    req_wstrb,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [N_REQ*DATA_WIDTH-1:0] rsp_rdata,
  output logic [NUM_COL-1:0]          weA,
  output logic [NUM_COL-1:0]          weB,
  output logic [ADDR_WIDTH-1:0]       addrA,
  output logic [ADDR_WIDTH-1:0]       addrB,
  output logic [DATA_WIDTH-1:0]       wdataA,
  output logic [DATA_WIDTH-1:0]       wdataB,
  input  logic [DATA_WIDTH-1:0]       rdataA,
  input  logic [DATA_WIDTH-1:0]       rdataB
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [ADDR_WIDTH-1:0] addr_arr  [N_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [N_REQ];
  logic [NUM_COL-1:0]    wstrb_arr [N_REQ];

  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_b;
  logic [N_REQ-1:0] gnt_a, gnt_b, req_b;
  logic [ID_W-1:0]  idx_a, idx_b;
  logic             found_a, found_b;
  logic             wr_a, wr_b, conflict, act_a, act_b;
  port_rec_t        rec_a, rec_b;

  // Unpack flat request buses into per-requester views.
  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      wstrb_arr[i] = req_wstrb[i*NUM_COL +: NUM_COL];
    end
  end

  iob_rr_sel #(.N_REQ(N_REQ), .ID_W(ID_W)) u_sel_a (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt_c   (gnt_a),
    .idx_c   (idx_a),
    .found_c (found_a)
  );

  assign req_b = req_valid & ~gnt_a;
  assign ptr_b = ID_W'(wrap_inc(32'(idx_a), N_REQ));

  iob_rr_sel #(.N_REQ(N_REQ), .ID_W(ID_W)) u_sel_b (
    .req     (req_b),
    .ptr     (ptr_b),
    .gnt_c   (gnt_b),
    .idx_c   (idx_b),
    .found_c (found_b)
  );

  // Two writes to one address would collide in the rf; B backs off and retries.
  assign wr_a     = |wstrb_arr[idx_a];
  assign wr_b     = |wstrb_arr[idx_b];
  assign conflict = wr_a && wr_b && (addr_arr[idx_a] == addr_arr[idx_b]);
  assign act_a    = arst_n && found_a;
  assign act_b    = arst_n && found_a && found_b && !conflict;

  // Handshake back to requesters.
  always_comb begin
    req_ready = '0;
    if (act_a) req_ready = req_ready | gnt_a;
    if (act_b) req_ready = req_ready | gnt_b;
  end

  // Register-file port drive; idle ports are held at zero.
  always_comb begin
    weA    = '0;
    addrA  = '0;
    wdataA = '0;
    weB    = '0;
    addrB  = '0;
    wdataB = '0;
    if (act_a) begin
      weA    = wstrb_arr[idx_a];
      addrA  = addr_arr[idx_a];
      wdataA = wdata_arr[idx_a];
    end
    if (act_b) begin
      weB    = wstrb_arr[idx_b];
      addrB  = addr_arr[idx_b];
      wdataB = wdata_arr[idx_b];
    end
  end

  // Remember which requester owns each port's read data next cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rec_a <= '0;
      rec_b <= '0;
    end else begin
      rec_a <= '{valid: act_a, is_read: act_a && !wr_a, id: ID_MAX_W'(idx_a)};
      rec_b <= '{valid: act_b, is_read: act_b && !wr_b, id: ID_MAX_W'(idx_b)};
    end
  end

`ifdef IOB_REG_FILE_ARB_RR_EN
  logic [ID_W-1:0] ptr_d;

  // Next pointer: one past the highest-order granted requester.
  always_comb begin
    ptr_d = ptr_q;
    if (act_b)      ptr_d = ID_W'(wrap_inc(32'(idx_b), N_REQ));
    else if (act_a) ptr_d = ID_W'(wrap_inc(32'(idx_a), N_REQ));
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  assign ptr_q = '0;
`endif

  // Route each port's read data to the requester that issued the read.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (rec_a.valid && rec_a.is_read && rec_a.id == ID_MAX_W'(i)) begin
        rsp_valid[i] = 1'b1;
        rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = rdataA;
      end
      if (rec_b.valid && rec_b.is_read && rec_b.id == ID_MAX_W'(i)) begin
        rsp_valid[i] = 1'b1;
        rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = rdataB;
      end
    end
  end

endmodule

// File: tb/tb_iob_reg_file_arb.sv
// Bench for iob_reg_file_arb: directed vectors, read responses checked by a scoreboard.
module tb_iob_reg_file_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned NC = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic            clk = 1'b0;
  logic            arst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*NC-1:0] req_wstrb;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_rdata;
  logic [NC-1:0]   weA, weB;
  logic [AW-1:0]   addrA, addrB;
  logic [DW-1:0]   wdataA, wdataB;
  logic [DW-1:0]   rdataA, rdataB;

  always #5 clk = ~clk;

  iob_reg_file_arb #(
    .N_REQ(N), .NUM_COL(NC), .COL_WIDTH(CW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .weA(weA), .weB(weB), .addrA(addrA), .addrB(addrB),
    .wdataA(wdataA), .wdataB(wdataB), .rdataA(rdataA), .rdataB(rdataB)
  );

  // Dual-port register file: per-column writes, registered read of pre-write data.
  logic [DW-1:0] mem [16];
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int k = 0; k < 16; k++) mem[k] <= DW'(32'h10 + k);
      mem_init <= 1'b1;
    end else begin
      for (int c = 0; c < int'(NC); c++) begin
        if (weA[c]) mem[addrA][c*CW +: CW] <= wdataA[c*CW +: CW];
        if (weB[c]) mem[addrB][c*CW +: CW] <= wdataB[c*CW +: CW];
      end
    end
    rdataA <= mem[addrA];
    rdataB <= mem[addrB];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned   due;
    int unsigned   id;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    req_valid[i]          = 1'b1;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = '0;
    req_wstrb[i*NC +: NC] = '0;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NC-1:0] s);
    req_valid[i]          = 1'b1;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_wstrb[i*NC +: NC] = s;
  endtask

  task automatic clr(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected read response, due the cycle after the current grant cycle.
  task automatic exp_rd(input int unsigned id, input logic [DW-1:0] d);
    sbq.push_back('{due: cyc + 1, id: id, data: d});
  endtask

  task automatic port_chk(input string tag, input logic [N-1:0] rdy,
                          input logic [NC-1:0] wa, input logic [AW-1:0] aa,
                          input logic [NC-1:0] wb, input logic [AW-1:0] ab);
    @(negedge clk);
    chk({tag, " ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, " weA"},   32'(weA),       32'(wa));
    chk({tag, " addrA"}, 32'(addrA),     32'(aa));
    chk({tag, " weB"},   32'(weB),       32'(wb));
    chk({tag, " addrB"}, 32'(addrB),     32'(ab));
  endtask

  task automatic do_reset(input string tag);
    for (int i = 0; i < int'(N); i++) set_wr(i, AW'(i), 8'hFF, 2'b11);
    arst_n = 1'b0;
    #1;
    chk({tag, " ready"},     32'(req_ready), 32'h0);
    chk({tag, " weA"},       32'(weA),       32'h0);
    chk({tag, " weB"},       32'(weB),       32'h0);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'h0);
    tick();
    req_valid = '0;
    arst_n    = 1'b1;
  endtask

  // Scoreboard monitor: every presented response must match the head of the queue.
  always @(negedge clk) begin
    if (arst_n) begin
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        mon_e = sbq.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL rsp missing: requester %0d never responded, expected %h at cycle %0d",
                 mon_e.id, mon_e.data, mon_e.due);
      end
      for (int i = 0; i < int'(N); i++) begin
        if (rsp_valid[i]) begin
          n_vec++;
          if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL rsp unexpected: requester %0d data %h, expected no response",
                     i, rsp_rdata[i*DW +: DW]);
          end else begin
            mon_e = sbq.pop_front();
            if (mon_e.id != 32'(i) || mon_e.due != cyc || mon_e.data !== rsp_rdata[i*DW +: DW]) begin
              n_err++;
              $display("FAIL rsp: got req %0d data %h cycle %0d, expected req %0d data %h cycle %0d",
                       i, rsp_rdata[i*DW +: DW], cyc, mon_e.id, mon_e.data, mon_e.due);
            end
          end
        end
      end
      for (int i = 0; i < int'(N); i++) begin
        if (!rsp_valid[i]) begin
          n_vec++;
          if (rsp_rdata[i*DW +: DW] !== '0) begin
            n_err++;
            $display("FAIL rsp idle slice %0d: got %h expected 00", i, rsp_rdata[i*DW +: DW]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("rst0");

    // Single writer uses port A only.
    set_wr(0, 4'd3, 8'hA5, 2'b11);
    port_chk("t1", 4'b0001, 2'b11, 4'd3, 2'b00, 4'd0);
    chk("t1 wdataA", 32'(wdataA), 32'h0A5);
    tick(); clr(0);

    // Read back with one-cycle latency.
    set_rd(0, 4'd3);
    port_chk("t2", 4'b0001, 2'b00, 4'd3, 2'b00, 4'd0);
    exp_rd(0, 8'hA5);
    tick(); clr(0);
    tick();

    // Four readers contend for three cycles.
    do_reset("rst3");
    for (int i = 0; i < int'(N); i++) set_rd(i, AW'(i));
    port_chk("t3c1", 4'b0011, 2'b00, 4'd0, 2'b00, 4'd1);
    exp_rd(0, 8'h10); exp_rd(1, 8'h11);
    tick();
`ifdef IOB_REG_FILE_ARB_RR_EN
    port_chk("t3c2", 4'b1100, 2'b00, 4'd2, 2'b00, 4'd3);
    exp_rd(2, 8'h12); exp_rd(3, 8'hA5);
`else
    port_chk("t3c2", 4'b0011, 2'b00, 4'd0, 2'b00, 4'd1);
    exp_rd(0, 8'h10); exp_rd(1, 8'h11);
`endif
    tick();
    port_chk("t3c3", 4'b0011, 2'b00, 4'd0, 2'b00, 4'd1);
    exp_rd(0, 8'h10); exp_rd(1, 8'h11);
    tick(); req_valid = '0;
    tick();

    // Write-write collision on one address: B retries next cycle.
    do_reset("rst4");
    set_wr(1, 4'd5, 8'h3C, 2'b11);
    set_wr(2, 4'd5, 8'hC3, 2'b11);
    port_chk("t4c1", 4'b0010, 2'b11, 4'd5, 2'b00, 4'd0);
    chk("t4c1 wdataA", 32'(wdataA), 32'h03C);
    tick(); clr(1);
    port_chk("t4c2", 4'b0100, 2'b11, 4'd5, 2'b00, 4'd0);
    chk("t4c2 wdataA", 32'(wdataA), 32'h0C3);
    tick(); clr(2);
    set_rd(0, 4'd5);
    port_chk("t4c3", 4'b0001, 2'b00, 4'd5, 2'b00, 4'd0);
    exp_rd(0, 8'hC3);
    tick(); clr(0);
    tick();

    // Reset with a read in flight drops the response and clears the pointer.
    do_reset("rst5");
    set_rd(0, 4'd0);
    port_chk("t5c1", 4'b0001, 2'b00, 4'd0, 2'b00, 4'd0);
    exp_rd(0, 8'h10);
    tick(); clr(0);
    set_rd(1, 4'd1);
    port_chk("t5c2", 4'b0010, 2'b00, 4'd1, 2'b00, 4'd0);
    #2;
    arst_n = 1'b0;
    #1;
    chk("t5 rst ready",     32'(req_ready), 32'h0);
    chk("t5 rst weA",       32'(weA),       32'h0);
    chk("t5 rst rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    arst_n = 1'b1;
    clr(1);
    set_rd(0, 4'd0);
    set_rd(2, 4'd2);
    port_chk("t5c3", 4'b0101, 2'b00, 4'd0, 2'b00, 4'd2);
    chk("t5 dropped rsp", 32'(rsp_valid), 32'h0);
    exp_rd(0, 8'h10); exp_rd(2, 8'h12);
    tick(); req_valid = '0;
    tick();

    // Two steady requesters: reader on A, column-masked writer on B every cycle.
    do_reset("rst6");
    set_rd(0, 4'd3);
    set_wr(3, 4'd7, 8'h5A, 2'b10);
    for (int c = 0; c < 4; c++) begin
      port_chk("t6", 4'b1001, 2'b00, 4'd3, 2'b10, 4'd7);
      chk("t6 wdataB", 32'(wdataB), 32'h05A);
      exp_rd(0, 8'hA5);
      tick();
    end
    req_valid = '0;
    set_rd(1, 4'd7);
    port_chk("t6 rd", 4'b0010, 2'b00, 4'd7, 2'b00, 4'd0);
    exp_rd(1, 8'h57);
    tick(); clr(1);
    tick();
    tick();

    chk("scoreboard drained", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
